// File: rtl/seconds_timer.sv
// Countdown timer answering the traffic-light FSM's timing handshake: latches a duration in
// seconds, counts it down, then pulses finished. Optional build macro: TIMER_FAST_SIM_EN.
module seconds_timer #(
    parameter int unsigned CLK_HZ = 10000,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [CNT_W-1:0] seconds_to_count,
    output logic             finished,
    output logic [CNT_W-1:0] seconds_left,
    output logic             busy
);

    localparam int unsigned      PRESC_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRESC_W-1:0] PRESC_TC = PRESC_W'(CLK_HZ - 1);

    typedef enum logic [1:0] {
        StKick,
        StLoad,
        StRun
    } state_e;

    state_e             state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0]   seconds_left_q, seconds_left_d;
    logic               finished_q, finished_d;
    logic               busy_q, busy_d;
    logic               sec_tick;

`ifdef TIMER_FAST_SIM_EN
    assign sec_tick = 1'b1;
`else
    assign sec_tick = (presc_q == PRESC_TC);
`endif

    always_comb begin
        state_d        = state_q;
        presc_d        = presc_q;
        seconds_left_d = seconds_left_q;
        finished_d     = 1'b0;
        busy_d         = busy_q;
        if (enable) begin
            unique case (state_q)
                StKick: begin
                    finished_d = 1'b1;
                    state_d    = StLoad;
                end
                StLoad: begin
                    // The pulse cycle itself is spent in LOAD; latch only once the FSM has
                    // had the finished edge to present its next duration.
                    if (!finished_q) begin
                        seconds_left_d = (seconds_to_count == '0) ? CNT_W'(1) : seconds_to_count;
                        presc_d        = '0;
                        busy_d         = 1'b1;
                        state_d        = StRun;
                    end
                end
                StRun: begin
                    if (sec_tick) begin
                        presc_d = '0;
                        if (seconds_left_q == CNT_W'(1)) begin
                            seconds_left_d = '0;
                            busy_d         = 1'b0;
                            finished_d     = 1'b1;
                            state_d        = StLoad;
                        end else begin
                            seconds_left_d = seconds_left_q - CNT_W'(1);
                        end
                    end else begin
                        presc_d = presc_q + PRESC_W'(1);
                    end
                end
                default: state_d = StKick;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StKick;
            presc_q        <= '0;
            seconds_left_q <= '0;
            finished_q     <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            presc_q        <= presc_d;
            seconds_left_q <= seconds_left_d;
            finished_q     <= finished_d;
            busy_q         <= busy_d;
        end
    end

    assign finished     = finished_q;
    assign seconds_left = seconds_left_q;
    assign busy         = busy_q;

endmodule
